// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   OP_*        : op-field encodings (values 6-7 are reserved and ignored)
//   mdu_state_e : FSM state encoding for alu_muldiv
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/alu_muldiv_if.sv
// Pipeline-side handshake bundle for alu_muldiv.
//   master (pipeline): drives start/op/oper1/oper2/flush, reads hi/lo/busy/done/div_zero
//   slave  (mdu)     : the reverse
interface alu_muldiv_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] oper1;
    logic [WIDTH-1:0] oper2;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, oper1, oper2, flush,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, oper1, oper2, flush,
        output hi, lo, busy, done, div_zero
    );

endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational conditional negation used for both operand magnitude
// prep and final sign correction.
//   val    : {upper half, lower half}
//   wide   : 1 = treat val as one 2*WIDTH-bit number (negated when neg_hi)
//            0 = negate halves independently (neg_hi / neg_lo)
//   res    : corrected value
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] val,
    input  logic               wide,
    input  logic               neg_hi,
    input  logic               neg_lo,
    output logic [2*WIDTH-1:0] res
);

    logic [2*WIDTH-1:0] full_n;
    logic [WIDTH-1:0]   hi_n;
    logic [WIDTH-1:0]   lo_n;

    assign full_n = -val;
    assign hi_n   = -val[2*WIDTH-1:WIDTH];
    assign lo_n   = -val[WIDTH-1:0];

    always_comb begin
        res = val;
        if (wide) begin
            if (neg_hi) res = full_n;
        end else begin
            if (neg_hi) res[2*WIDTH-1:WIDTH] = hi_n;
            if (neg_lo) res[WIDTH-1:0]       = lo_n;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu_muldiv_if.slave (start/op/oper1/oper2/flush in;
//                hi/lo/busy/done/div_zero out)
// Mul/div take WIDTH+1 cycles (WIDTH shift steps + one sign-fix cycle);
// MTHI/MTLO write in the cycle they are accepted.
module alu_muldiv
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_muldiv_if.slave  bus
);

    mdu_state_e state_q, state_d;

    logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {rem, quo}
    logic [WIDTH-1:0]   opb_q;      // multiplicand / divisor magnitude
    logic               is_div_q;
    logic               dz_q;       // this op divides by zero
    logic               neg_hi_q;   // negate product (mul) / remainder (div)
    logic               neg_lo_q;   // negate quotient
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               div_zero_q;
    logic               dz_save_q;  // div_zero before this op, restored on flush

    // ---------------- request decode ----------------
    logic op_md, op_mt, op_signed, op_div, div0, s1, s2;

    assign op_md     = bus.start && !bus.flush && !bus.op[2];
    assign op_mt     = bus.start && !bus.flush &&
                       (bus.op == OP_MTHI || bus.op == OP_MTLO);
    assign op_signed = !bus.op[0];
    assign op_div    = bus.op[1];
    assign div0      = op_div && (bus.oper2 == '0);
    assign s1        = bus.oper1[WIDTH-1];
    assign s2        = bus.oper2[WIDTH-1];

    // Divide-by-zero keeps the dividend raw so the restoring loop naturally
    // yields rem = oper1, quo = all-ones with no sign fix afterwards.
    logic [2*WIDTH-1:0] mags;
    logic [WIDTH-1:0]   mag_a, mag_b;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_prep (
        .val    ({bus.oper1, bus.oper2}),
        .wide   (1'b0),
        .neg_hi (op_signed && s1 && !div0),
        .neg_lo (op_signed && s2),
        .res    (mags)
    );

    assign mag_a = mags[2*WIDTH-1:WIDTH];
    assign mag_b = mags[WIDTH-1:0];

    // ---------------- one radix-2 step ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Remainder stays below 2^WIDTH after a successful subtract, so only the
    // low WIDTH bits of diff are kept.
    assign trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = trial - {1'b0, opb_q};
    assign div_next = (trial >= {1'b0, opb_q})
                    ? {diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1}
                    : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    // ---------------- result sign fix ----------------
    logic [2*WIDTH-1:0] res;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .val    (acc_q),
        .wide   (!is_div_q),
        .neg_hi (neg_hi_q),
        .neg_lo (neg_lo_q),
        .res    (res)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (op_md) state_d = ST_CALC;
            ST_CALC: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            neg_hi_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            dz_save_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_md) begin
                        acc_q      <= {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
                        opb_q      <= op_div ? mag_b : mag_a;
                        is_div_q   <= op_div;
                        dz_q       <= div0;
                        neg_hi_q   <= op_div ? (op_signed && s1 && !div0)
                                             : (op_signed && (s1 ^ s2));
                        neg_lo_q   <= op_div && op_signed && (s1 ^ s2) && !div0;
                        cnt_q      <= '0;
                        dz_save_q  <= div_zero_q;
                        div_zero_q <= 1'b0;
                    end else if (op_mt) begin
                        if (bus.op == OP_MTHI) hi_q <= bus.oper1;
                        else                   lo_q <= bus.oper1;
                    end
                end
                ST_CALC: begin
                    if (bus.flush) begin
                        div_zero_q <= dz_save_q;
                    end else begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    if (bus.flush) begin
                        div_zero_q <= dz_save_q;
                    end else begin
                        hi_q       <= res[2*WIDTH-1:WIDTH];
                        lo_q       <= res[WIDTH-1:0];
                        done_q     <= 1'b1;
                        div_zero_q <= dz_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;

    alu_muldiv_if #(.WIDTH(W)) bus ();

    alu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // expected {div_zero, hi, lo}
    logic [2*W:0] sb[$];
    logic [W-1:0] last_hi, last_lo;
    logic         last_dz;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [2*W:0] model(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb_;
        int     ia, ib;
        logic [63:0] p;
        model = '0;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a)); sb_ = longint'($signed(b));
                p = 64'(sa * sb_);
                model = {1'b0, p};
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                model = {1'b0, p};
            end
            OP_DIV: begin
                if (b == 0)                                  model = {1'b1, a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == '1)      model = {1'b0, 32'd0, 32'h8000_0000};
                else begin
                    ia = $signed(a); ib = $signed(b);
                    model = {1'b0, 32'(ia % ib), 32'(ia / ib)};
                end
            end
            OP_DIVU: begin
                if (b == 0) model = {1'b1, a, 32'hFFFF_FFFF};
                else        model = {1'b0, a % b, a / b};
            end
            default: model = '0;
        endcase
    endfunction

    // Caller sits at a negedge; returns at the negedge after the sampling edge.
    task automatic go(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W:0] exp, input bit push);
        if (push) sb.push_back(exp);
        bus.start = 1'b1; bus.op = op; bus.oper1 = a; bus.oper2 = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        bit seen, dropped;
        logic [2*W:0] e;
        cyc = 0; seen = 0; dropped = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done)      seen = 1'b1;
            else if (!bus.busy) dropped = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_held", 64'(dropped), 64'd0);
        if (seen) begin
            chk("busy_clr", 64'(bus.busy), 64'd0);
            chk("sb_size", 64'(sb.size()), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("hi", 64'(bus.hi), 64'(e[63:32]));
                chk("lo", 64'(bus.lo), 64'(e[31:0]));
                chk("div_zero", 64'(bus.div_zero), 64'(e[64]));
                last_hi = e[63:32]; last_lo = e[31:0]; last_dz = e[64];
            end
        end
    endtask

    task automatic quiet(input int n, output bit saw_done);
        saw_done = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
    endtask

    int       cyc;
    bit       saw;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.oper1 = '0; bus.oper2 = '0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dz", 64'(bus.div_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT -3 * 5, latency and busy
        go(OP_MULT, 32'hFFFF_FFFD, 32'd5, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1);
        chk("busy_set", 64'(bus.busy), 64'd1);
        wait_done(cyc);
        chk("latency", 64'(cyc), 64'd33);

        // MULTU max*max, then back-to-back start in the done cycle
        go(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, 1);
        wait_done(cyc);
        go(OP_MULTU, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6}, 1);
        wait_done(cyc);
        chk("b2b_latency", 64'(cyc), 64'd33);

        // signed divides
        go(OP_DIV, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1);
        wait_done(cyc);
        go(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0, 32'h8000_0000}, 1);
        wait_done(cyc);

        // divide by zero, then flag cleared by the next start edge
        go(OP_DIVU, 32'd7, 32'd0, {1'b1, 32'd7, 32'hFFFF_FFFF}, 1);
        wait_done(cyc);
        chk("dz_latency", 64'(cyc), 64'd33);
        go(OP_MULTU, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12}, 1);
        chk("dz_clr_at_start", 64'(bus.div_zero), 64'd0);
        wait_done(cyc);

        // MTHI / MTLO and a reserved op
        go(OP_MTHI, 32'h1234, 32'd0, '0, 0);
        chk("mthi_hi", 64'(bus.hi), 64'h1234);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        go(OP_MTLO, 32'h5678, 32'd0, '0, 0);
        chk("mtlo_lo", 64'(bus.lo), 64'h5678);
        chk("mtlo_hi", 64'(bus.hi), 64'h1234);
        go(3'd6, 32'hDEAD, 32'hBEEF, '0, 0);
        chk("rsvd_busy", 64'(bus.busy), 64'd0);
        quiet(3, saw);
        chk("mt_no_done", 64'(saw), 64'd0);
        chk("rsvd_hi", 64'(bus.hi), 64'h1234);
        chk("rsvd_lo", 64'(bus.lo), 64'h5678);

        // start during busy is ignored
        go(OP_DIVU, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14}, 1);
        repeat (3) @(negedge clk);
        go(OP_MULT, 32'd5, 32'd5, '0, 0);
        wait_done(cyc);
        quiet(40, saw);
        chk("ignored_no_done", 64'(saw), 64'd0);

        // random mul/div against the model
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (i == 0) rb = 32'd0;
            go(rop, ra, rb, model(rop, ra, rb), 1);
            wait_done(cyc);
        end

        // flush mid-operation
        go(OP_MULTU, 32'd9, 32'd9, '0, 0);
        repeat (8) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        quiet(40, saw);
        chk("flush_no_done", 64'(saw), 64'd0);
        chk("flush_hi", 64'(bus.hi), 64'(last_hi));
        chk("flush_lo", 64'(bus.lo), 64'(last_lo));
        chk("flush_dz", 64'(bus.div_zero), 64'(last_dz));

        // reset mid-operation
        go(OP_MULTU, 32'd9, 32'd9, '0, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_hi", 64'(bus.hi), 64'd0);
        chk("mrst_lo", 64'(bus.lo), 64'd0);
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        quiet(40, saw);
        chk("mrst_no_done", 64'(saw), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised iterative multiply/divide unit, the multi-cycle companion to the single-cycle `alu` in the MIPS datapath. It executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers, and services MTHI/MTLO writes. A start/busy/done handshake lets the pipeline stall on reads of HI/LO while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  synchronous reset, active-low.
start  in  1  request; sampled only when busy=0.
op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6-7 reserved, treated as no-op.
oper1  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
oper2  in  WIDTH  multiplier / divisor.
flush  in  1  abort in-flight operation (exception/branch squash).
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
busy  out  1  operation in flight.
done  out  1  one-cycle pulse: hi/lo just updated by mul/div.
div_zero  out  1  sticky-until-next-start flag: last DIV/DIVU had divisor 0.

Behaviour:
- Reset (rst_n=0 at edge): hi=0, lo=0, busy=0, done=0, div_zero=0, FSM→IDLE, counter=0. Applies mid-operation; result discarded.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, op∈{0..3}, edge 0: latch operand magnitudes (abs for signed ops), result signs, op class; clear div_zero; →CALC; busy=1 from edge 0.
- CALC: one radix-2 step per edge (shift-add multiply / restoring divide), edges 1..WIDTH; after edge WIDTH →FIX.
- FIX, edge WIDTH+1: apply sign correction, write hi/lo, done=1 for exactly one cycle, busy=0, →IDLE. Latency is WIDTH+1 cycles (33 for WIDTH=32).
- A new start may be sampled in the cycle done=1, giving back-to-back operation.
- MULT/MULTU: {hi,lo} = 2·WIDTH-bit product. Signed ops are sign-corrected two's complement.
- DIV/DIVU: lo=quotient, hi=remainder. Quotient truncates toward zero. Remainder takes the dividend's sign.
- DIV of MIN by −1: lo=MIN, hi=0, no flag.
- Divisor 0: full latency still taken; lo=all-ones, hi=oper1 (unsigned raw value for both DIV and DIVU); div_zero=1.
- MTHI/MTLO with start=1 in IDLE: hi (resp. lo)=oper1 at edge 0; no busy, no done, div_zero unchanged.
- start while busy: ignored, no queuing, operand inputs ignored.
- Reserved op: ignored entirely.
- flush=1 at any edge: FSM→IDLE, busy=0, done=0; hi/lo/div_zero keep pre-operation values. Flush has priority over start in the same cycle; reset has priority over everything.
- flush in IDLE: no effect.
- hi/lo are only ever written at FIX, on MTHI/MTLO, or by reset.

Decomposition:
- Package mdu_pkg: op encoding localparams (OP_MULT…OP_MTLO) and the FSM state enum encoding.
- Natural sub-module: mdu_sign_fix (combinational abs/negate of operands and results, parametrised by WIDTH), instantiated twice: operand prep and result fix.
- FSM, counter and shift datapath stay in alu_muldiv.

Test Plan:
- MULT oper1=0xFFFFFFFD (−3), oper2=5 → done after 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for cycles 1..32.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; then immediate start in the done cycle with MULTU 2×3 → hi=0, lo=6.
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- DIVU 7/0 → lo=0xFFFFFFFF, hi=7, div_zero=1; next MULTU clears div_zero at its start edge.
- MTHI 0x1234 then MTLO 0x5678 → hi=0x1234, lo=0x5678 after one edge each, done never pulses. Start DIVU 100/7, pulse start with MULT during busy → ignored; hi=2, lo=14.
- Start MULTU 9×9, flush at cycle 10 → busy=0 next cycle, no done, hi/lo unchanged. Repeat with rst_n=0 at cycle 10 → hi=lo=0, busy=0.
